demux_stream_1ton: RTL

//  Parametrised, buffered 1-to-N stream demultiplexer with enable; next generation of the 1-to-4 enable demux.

---
 rtl/demux_stream_1ton_pkg.sv | 14 +
 rtl/demux_stream_1ton_chan_fifo.sv | 54 +++++
 rtl/demux_stream_1ton.sv | 93 +++++++++
 3 files changed

// File: rtl/demux_stream_1ton_pkg.sv
// Shared constants and helpers for the buffered 1-to-N stream demultiplexer.
package demux_stream_1ton_pkg;

  localparam int unsigned DROP_CNT_W = 8;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/demux_stream_1ton_chan_fifo.sv
// Per-channel DEPTH-entry FIFO; a full FIFO refuses a push even when popped in the same cycle.
module demux_stream_1ton_chan_fifo
  import demux_stream_1ton_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            data,
  input  logic                        pop,
  output logic                        full,
  output logic [clog2(DEPTH):0]       count,
  output logic [WIDTH-1:0]            head
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: its contents are masked until count says valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/demux_stream_1ton.sv
// Buffered 1-to-N stream demux with enable, unicast/broadcast routing and illegal-select drop counter.
module demux_stream_1ton
  import demux_stream_1ton_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [clog2(N)-1:0]   in_sel,
  input  logic                  in_bcast,
  output logic [N-1:0]          out_valid,
  input  logic [N-1:0]          out_ready,
  output logic [N*WIDTH-1:0]    out_data,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned SEL_W    = clog2(N);
  localparam int unsigned SEL_SPAN = 1 << SEL_W;
  localparam int unsigned CNT_W    = clog2(DEPTH) + 1;

  logic [N-1:0]        full;
  logic [N-1:0]        push;
  logic [CNT_W-1:0]    cnt  [N];
  logic [WIDTH-1:0]    head [N];
  logic [SEL_SPAN-1:0] legal_map;
  logic [SEL_SPAN-1:0] full_ext;
  logic                sel_legal;
  logic                accept;
  logic                drop;

  // Select codes at or beyond N are illegal and never see a full FIFO.
  for (genvar s = 0; s < SEL_SPAN; s++) begin : g_sel
    if (s < N) begin : g_legal
      assign legal_map[s] = 1'b1;
      assign full_ext[s]  = full[s];
    end else begin : g_illegal
      assign legal_map[s] = 1'b0;
      assign full_ext[s]  = 1'b0;
    end
  end

  assign sel_legal = legal_map[in_sel];

  // Ready depends only on registered counts and en, never on out_ready.
  always_comb begin
    in_ready = 1'b0;
    if (en) begin
      if (in_bcast)       in_ready = ~|full;
      else if (sel_legal) in_ready = ~full_ext[in_sel];
      else                in_ready = 1'b1;
    end
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & ~in_bcast & ~sel_legal;

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign push[k] = accept & (in_bcast | (sel_legal & (in_sel == SEL_W'(k))));

    demux_stream_1ton_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[k]),
      .data  (in_data),
      .pop   (out_ready[k]),
      .full  (full[k]),
      .count (cnt[k]),
      .head  (head[k])
    );

    assign out_valid[k]                 = (cnt[k] != '0);
    assign out_data[k*WIDTH +: WIDTH]   = out_valid[k] ? head[k] : '0;
  end

  // Saturating drop counter for words consumed with an illegal select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

endmodule
